// File: rtl/timing_gen.sv
// Beat/phase timing generator: synchronized start button, three-phase beats
// (T1..T3) within one-hot beats (W1..W3), step/stop halting and a beat counter.
module timing_gen (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       QD,
  input  logic       STEP,
  input  logic       SHORT,
  input  logic       LONG,
  input  logic       STOP,
  output logic       T1,
  output logic       T2,
  output logic       T3,
  output logic       W1,
  output logic       W2,
  output logic       W3,
  output logic       RUN,
  output logic       IDONE,
  output logic [7:0] BEATS
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [2:0] BEAT_W1 = 3'b100;
  localparam logic [2:0] BEAT_W2 = 3'b010;
  localparam logic [2:0] BEAT_W3 = 3'b001;

  state_t     r_state;
  logic       r_qd1, r_qd2, r_qd3;
  logic [1:0] r_vld;
  logic       r_armed;
  logic [2:0] r_t;       // {T1,T2,T3}
  logic [2:0] r_w;       // {W1,W2,W3}
  logic       r_run;
  logic       r_idone;
  logic [7:0] r_beats;

  logic       w_start;
  logic [2:0] w_wnext;
  logic       w_halt;

  // The edge detector only arms once the synchronizer holds a genuine low
  // sample taken after reset, so a QD held high through reset cannot start.
  assign w_start = r_qd2 & ~r_qd3 & r_armed;

  always_comb begin
    w_wnext = BEAT_W1;
    case (r_w)
      BEAT_W1: w_wnext = SHORT ? BEAT_W1 : BEAT_W2;
      BEAT_W2: w_wnext = LONG  ? BEAT_W3 : BEAT_W1;
      default: w_wnext = BEAT_W1;
    endcase
  end

  assign w_halt = STOP | (STEP & (w_wnext == BEAT_W1));

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state <= S_IDLE;
      r_qd1   <= 1'b0;
      r_qd2   <= 1'b0;
      r_qd3   <= 1'b0;
      r_vld   <= '0;
      r_armed <= 1'b0;
      r_t     <= '0;
      r_w     <= BEAT_W1;
      r_run   <= 1'b0;
      r_idone <= 1'b0;
      r_beats <= '0;
    end else begin
      r_qd1   <= QD;
      r_qd2   <= r_qd1;
      r_qd3   <= r_qd2;
      r_vld   <= {r_vld[0], 1'b1};
      if (r_vld[1] && !r_qd2) r_armed <= 1'b1;
      r_idone <= 1'b0;
      case (r_state)
        S_IDLE, S_HALT: begin
          if (w_start) begin
            r_state <= S_RUN;
            r_run   <= 1'b1;
            r_t     <= 3'b100;
          end
        end
        S_RUN: begin
          if (r_t == 3'b001) begin
            r_w     <= w_wnext;
            r_beats <= r_beats + 8'd1;
            r_idone <= (w_wnext == BEAT_W1);
            if (w_halt) begin
              r_state <= S_HALT;
              r_run   <= 1'b0;
              r_t     <= '0;
            end else begin
              r_t     <= 3'b100;
            end
          end else begin
            r_t <= {1'b0, r_t[2:1]};
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_run   <= 1'b0;
          r_t     <= '0;
        end
      endcase
    end
  end

  assign {T1, T2, T3} = r_t;
  assign {W1, W2, W3} = r_w;
  assign RUN   = r_run;
  assign IDONE = r_idone;
  assign BEATS = r_beats;

endmodule
